hazard_forward_ctrl: RTL and testbench
======================================

HAZARD_FORWARD_CTRL -- requirements
Module: hazard_forward_ctrl

Interface
REQ-001 SHALL have parameter NREG_W, default 3, width of register-number fields (8 GPRs).
REQ-002 SHALL have ports:
- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-low
- id_valid  in  1  ID-stage instruction present
- id_rs_a, id_rs_b, id_rs_c  in  NREG_W  source registers feeding ALU src A, ALU src B, store/output operand
- id_use_a, id_use_b, id_use_c  in  1  corresponding source is read
- id_rd  in  NREG_W  destination register
- id_we  in  1  instruction writes id_rd
- id_load  in  1  instruction is a memory load
- id_halt  in  1  instruction is HLT
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- op_forward_a, op_forward_b, op_forward_c  out  2  registered EX-stage forwarding selects
- stall  out  1  hold PC and IF/ID register
- bubble_ex  out  1  EX receives a NOP at next edge
- flush  out  1  squash IF and ID contents
- halted  out  1  pipeline drained after HLT
- stall_count  out  16  saturating count of load-use stall cycles

Function
REQ-003 SHALL keep shadow pipeline entries EX, MEM, WB, each holding {valid, rd, we, load}; every edge: WB<=MEM, MEM<=EX, EX<=ID entry, or invalid entry when bubble_ex=1.
REQ-004 SHALL encode selects as 0=register/base value, 1=MEM-stage result, 2=WB result; value 3 SHALL never be driven.
REQ-005 SHALL compute each select at the edge the ID instruction enters EX: 1 if use_x and EX entry valid, we, !load, rd==rs_x; else 2 if use_x and MEM entry valid, we, rd==rs_x; else 0.
REQ-006 SHALL give MEM-stage match (select 1) priority over WB-stage match (select 2).
REQ-007 SHALL drive all selects to 0 when a bubble enters EX.
REQ-008 SHALL assert stall and bubble_ex combinationally for load-use hazard: id_valid, and any used source equals rd of a valid, we, load EX entry.
REQ-009 SHALL stall at most 1 cycle per load-use hazard; after the stall the load sits in MEM and the consumer is forwarded with select 2.
REQ-010 SHALL, on ex_branch_taken, assert flush and bubble_ex and deassert stall in the same cycle; branch has priority over stall and halt.
REQ-011 SHALL implement FSM RUN, DRAIN, HALTED: RUN->DRAIN when id_valid & id_halt accepted (no stall, no flush); DRAIN->HALTED when EX, MEM, WB entries are all invalid; HALTED remains until reset.
REQ-012 SHALL, in DRAIN and HALTED, hold stall=1 and bubble_ex=1; halted=1 only in HALTED.
REQ-013 SHALL increment stall_count once per load-use stall cycle and saturate at 16'hFFFF.
REQ-014 SHALL treat id_valid=0 as a bubble: no stall, EX entry invalid.

Reset
REQ-015 SHALL, while reset=0 at an edge, clear all shadow entries to invalid, selects to 0, stall_count to 0, FSM to RUN; combinational outputs follow the cleared state.
REQ-016 SHALL let reset override every other input, including mid-DRAIN and mid-stall.

Structure
REQ-017 SHALL place select encodings (FWD_REG, FWD_MEM, FWD_WB) and FSM state encodings in a shared package.
REQ-018 SHALL use one sub-module, fwd_select, instantiated three times: (use, rs, EX entry, MEM entry) -> 2-bit select.

Verification
REQ-019 SHALL cover ALU-ALU back-to-back: ADD r1 then ADD r2,r1 (src A) -> op_forward_a=1 in consumer's EX cycle, no stall.
REQ-020 SHALL cover distance-2: write r3, unrelated instruction, read r3 on src B -> op_forward_b=2.
REQ-021 SHALL cover load-use: LD r4 then use r4 on src C -> stall=1 for exactly 1 cycle, stall_count 0->1, then op_forward_c=2.
REQ-022 SHALL cover double match: r5 written at distance 1 and 2 -> select 1.
REQ-023 SHALL cover branch taken during load-use stall -> flush=1, stall=0, stall_count unchanged.
REQ-024 SHALL cover HLT: halted=1 exactly 3 cycles after HLT leaves ID with full pipeline; reset=0 afterwards -> halted=0, state RUN.

Source files
------------

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared encodings for the hazard / forwarding controller.
package hazard_forward_ctrl_pkg;

  // EX-stage operand source selects
  localparam logic [1:0] FWD_REG = 2'd0;  // register file / base value
  localparam logic [1:0] FWD_MEM = 2'd1;  // result currently in MEM
  localparam logic [1:0] FWD_WB  = 2'd2;  // result currently in WB

  // Controller FSM states
  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  // 16-bit increment that sticks at all-ones
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Forwarding select for one ID-stage source operand, evaluated against
// the instructions that will sit in MEM and WB when it reaches EX.
module fwd_select
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int NREG_W = 3
) (
  input  logic              use_src,
  input  logic [NREG_W-1:0] rs,
  input  logic              ex_valid,
  input  logic              ex_we,
  input  logic              ex_load,
  input  logic [NREG_W-1:0] ex_rd,
  input  logic              mem_valid,
  input  logic              mem_we,
  input  logic [NREG_W-1:0] mem_rd,
  output logic [1:0]        sel
);

  // Youngest producer wins; a load one ahead has no result yet to forward
  always_comb begin
    sel = FWD_REG;
    if (use_src && ex_valid && ex_we && !ex_load && (ex_rd == rs)) begin
      sel = FWD_MEM;
    end else if (use_src && mem_valid && mem_we && (mem_rd == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and operand-forwarding control for a 5-stage pipeline.
// Tracks shadow copies of EX/MEM/WB occupancy, produces registered
// forwarding selects, load-use stalls, branch flushes and HLT draining.
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int NREG_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [NREG_W-1:0] id_rs_a,
  input  logic [NREG_W-1:0] id_rs_b,
  input  logic [NREG_W-1:0] id_rs_c,
  input  logic              id_use_a,
  input  logic              id_use_b,
  input  logic              id_use_c,
  input  logic [NREG_W-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              id_halt,
  input  logic              ex_branch_taken,
  output logic [1:0]        op_forward_a,
  output logic [1:0]        op_forward_b,
  output logic [1:0]        op_forward_c,
  output logic              stall,
  output logic              bubble_ex,
  output logic              flush,
  output logic              halted,
  output logic [15:0]       stall_count
);

  typedef struct packed {
    logic              valid;
    logic [NREG_W-1:0] rd;
    logic              we;
    logic              load;
  } ex_entry_t;

  // Only the fields later stages still consult are carried past EX. The WB
  // slot is simply the MEM entry one edge later and nothing reads it, so it
  // is not stored; the drain check looks at what each slot will hold next.
  typedef struct packed {
    logic              valid;
    logic [NREG_W-1:0] rd;
    logic              we;
  } mem_entry_t;

  ex_entry_t  ex_q;
  ex_entry_t  ex_d;
  mem_entry_t mem_q;
  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic [1:0] sel_c;
  logic       load_use;
  logic       lu_stall;
  logic       halt_accept;
  logic       pipe_empty_next;

  // Load in EX whose destination is read by the ID instruction
  always_comb begin
    load_use = id_valid && ex_q.valid && ex_q.we && ex_q.load &&
               ((id_use_a && (id_rs_a == ex_q.rd)) ||
                (id_use_b && (id_rs_b == ex_q.rd)) ||
                (id_use_c && (id_rs_c == ex_q.rd)));
  end

  // Pipeline control: taken branch beats stall, drain and halt
  always_comb begin
    flush     = ex_branch_taken;
    stall     = !ex_branch_taken && (load_use || (state_q != ST_RUN));
    bubble_ex = ex_branch_taken || stall;
    halted    = (state_q == ST_HALTED);
    lu_stall  = load_use && !ex_branch_taken && (state_q == ST_RUN);
  end

  // Entry that enters EX at the next edge; id_valid=0 becomes a bubble too
  always_comb begin
    ex_d.valid = id_valid && !bubble_ex;
    ex_d.rd    = id_rd;
    ex_d.we    = id_we;
    ex_d.load  = id_load;
  end

  // Halt FSM next state; drain ends when EX, MEM and WB will all be empty
  always_comb begin
    halt_accept     = (state_q == ST_RUN) && ex_d.valid && id_halt;
    pipe_empty_next = !ex_d.valid && !ex_q.valid && !mem_q.valid;
    state_d         = state_q;
    case (state_q)
      ST_RUN:    if (halt_accept) state_d = ST_DRAIN;
      ST_DRAIN:  if (pipe_empty_next) state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  fwd_select #(.NREG_W(NREG_W)) u_fwd_a (
    .use_src  (id_use_a),
    .rs       (id_rs_a),
    .ex_valid (ex_q.valid),
    .ex_we    (ex_q.we),
    .ex_load  (ex_q.load),
    .ex_rd    (ex_q.rd),
    .mem_valid(mem_q.valid),
    .mem_we   (mem_q.we),
    .mem_rd   (mem_q.rd),
    .sel      (sel_a)
  );

  fwd_select #(.NREG_W(NREG_W)) u_fwd_b (
    .use_src  (id_use_b),
    .rs       (id_rs_b),
    .ex_valid (ex_q.valid),
    .ex_we    (ex_q.we),
    .ex_load  (ex_q.load),
    .ex_rd    (ex_q.rd),
    .mem_valid(mem_q.valid),
    .mem_we   (mem_q.we),
    .mem_rd   (mem_q.rd),
    .sel      (sel_b)
  );

  fwd_select #(.NREG_W(NREG_W)) u_fwd_c (
    .use_src  (id_use_c),
    .rs       (id_rs_c),
    .ex_valid (ex_q.valid),
    .ex_we    (ex_q.we),
    .ex_load  (ex_q.load),
    .ex_rd    (ex_q.rd),
    .mem_valid(mem_q.valid),
    .mem_we   (mem_q.we),
    .mem_rd   (mem_q.rd),
    .sel      (sel_c)
  );

  // Shadow pipeline advance, registered selects, stall counter and FSM
  always_ff @(posedge clock) begin
    if (!reset) begin
      ex_q         <= '0;
      mem_q        <= '0;
      state_q      <= ST_RUN;
      op_forward_a <= FWD_REG;
      op_forward_b <= FWD_REG;
      op_forward_c <= FWD_REG;
      stall_count  <= '0;
    end else begin
      ex_q         <= ex_d;
      mem_q.valid  <= ex_q.valid;
      mem_q.rd     <= ex_q.rd;
      mem_q.we     <= ex_q.we;
      state_q      <= state_d;
      op_forward_a <= ex_d.valid ? sel_a : FWD_REG;
      op_forward_b <= ex_d.valid ? sel_b : FWD_REG;
      op_forward_c <= ex_d.valid ? sel_c : FWD_REG;
      if (lu_stall) begin
        stall_count <= sat_inc16(stall_count);
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed pipeline scenarios
// followed by randomized traffic, all checked against an instruction-level
// model of the pipeline kept below.
module tb_hazard_forward_ctrl;

  localparam int NREG_W = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [NREG_W-1:0] id_rs_a, id_rs_b, id_rs_c;
  logic              id_use_a, id_use_b, id_use_c;
  logic [NREG_W-1:0] id_rd;
  logic              id_we, id_load, id_halt;
  logic              ex_branch_taken;
  logic [1:0]        op_forward_a, op_forward_b, op_forward_c;
  logic              stall, bubble_ex, flush, halted;
  logic [15:0]       stall_count;

  always #5 clock = ~clock;

  hazard_forward_ctrl #(.NREG_W(NREG_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_rs_a        (id_rs_a),
    .id_rs_b        (id_rs_b),
    .id_rs_c        (id_rs_c),
    .id_use_a       (id_use_a),
    .id_use_b       (id_use_b),
    .id_use_c       (id_use_c),
    .id_rd          (id_rd),
    .id_we          (id_we),
    .id_load        (id_load),
    .id_halt        (id_halt),
    .ex_branch_taken(ex_branch_taken),
    .op_forward_a   (op_forward_a),
    .op_forward_b   (op_forward_b),
    .op_forward_c   (op_forward_c),
    .stall          (stall),
    .bubble_ex      (bubble_ex),
    .flush          (flush),
    .halted         (halted),
    .stall_count    (stall_count)
  );

  typedef struct {
    bit              v;
    logic [NREG_W-1:0] rs[3];
    bit              u[3];
    logic [NREG_W-1:0] rd;
    bit              we;
    bit              ld;
    bit              hlt;
  } ins_t;

  typedef enum {M_RUN, M_DRAIN, M_HALT} mode_t;

  // Model: hist[0] is the instruction one ahead (EX), hist[1] two ahead, hist[2] three ahead
  ins_t        hist[3];
  logic [1:0]  m_fwd[3];
  int unsigned m_cnt;
  mode_t       m_mode;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Values seen at the last step's sample point, for directed scenario checks
  logic [1:0]  obs_fwd[3];
  logic        obs_stall, obs_flush, obs_bubble, obs_halted;
  logic [15:0] obs_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ins_t mk(bit v, logic [NREG_W-1:0] rd, bit we, bit ld,
                              logic [NREG_W-1:0] ra, bit ua, logic [NREG_W-1:0] rb, bit ub,
                              logic [NREG_W-1:0] rc, bit uc, bit hlt);
    ins_t r;
    r.v = v; r.rd = rd; r.we = we; r.ld = ld; r.hlt = hlt;
    r.rs[0] = ra; r.rs[1] = rb; r.rs[2] = rc;
    r.u[0] = ua; r.u[1] = ub; r.u[2] = uc;
    return r;
  endfunction

  function automatic ins_t nop();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Nearest older producer of rs: one ahead only if its result is computed, else two ahead
  function automatic logic [1:0] model_src(bit u, logic [NREG_W-1:0] rs);
    for (int d = 0; d < 2; d++) begin
      if (u && hist[d].v && hist[d].we && hist[d].rd == rs && !(d == 0 && hist[d].ld))
        return 2'(d + 1);
    end
    return 2'd0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) hist[i] = nop();
    for (int i = 0; i < 3; i++) m_fwd[i] = 2'd0;
    m_cnt  = 0;
    m_mode = M_RUN;
  endtask

  // One clock cycle: drive, compare against the model, advance the model and the clock
  task automatic step(input bit rst_n, input ins_t in, input bit br);
    bit         lu, e_stall, e_bub, enter;
    logic [1:0] nf[3];
    mode_t      old_mode;
    ins_t       ent;
    reset           = rst_n;
    id_valid        = in.v;
    id_rs_a         = in.rs[0];
    id_rs_b         = in.rs[1];
    id_rs_c         = in.rs[2];
    id_use_a        = in.u[0];
    id_use_b        = in.u[1];
    id_use_c        = in.u[2];
    id_rd           = in.rd;
    id_we           = in.we;
    id_load         = in.ld;
    id_halt         = in.hlt;
    ex_branch_taken = br;
    #2;
    lu = 0;
    if (in.v && hist[0].v && hist[0].we && hist[0].ld)
      for (int i = 0; i < 3; i++) if (in.u[i] && in.rs[i] == hist[0].rd) lu = 1;
    e_stall = !br && (lu || m_mode != M_RUN);
    e_bub   = br || e_stall;
    check_eq("stall", stall, e_stall);
    check_eq("bubble_ex", bubble_ex, e_bub);
    check_eq("flush", flush, br);
    check_eq("halted", halted, m_mode == M_HALT);
    check_eq("fwd_a", op_forward_a, m_fwd[0]);
    check_eq("fwd_b", op_forward_b, m_fwd[1]);
    check_eq("fwd_c", op_forward_c, m_fwd[2]);
    check_eq("stall_count", stall_count, m_cnt);
    obs_fwd[0] = op_forward_a; obs_fwd[1] = op_forward_b; obs_fwd[2] = op_forward_c;
    obs_stall = stall; obs_flush = flush; obs_bubble = bubble_ex;
    obs_halted = halted; obs_cnt = stall_count;
    if (!rst_n) begin
      model_clear();
    end else begin
      enter = in.v && !e_bub;
      for (int i = 0; i < 3; i++) nf[i] = enter ? model_src(in.u[i], in.rs[i]) : 2'd0;
      for (int i = 0; i < 3; i++) m_fwd[i] = nf[i];
      if (lu && !br && m_mode == M_RUN && m_cnt < 65535) m_cnt++;
      old_mode = m_mode;
      if (old_mode == M_RUN && enter && in.hlt) m_mode = M_DRAIN;
      ent   = in;
      ent.v = enter;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = ent;
      if (old_mode == M_DRAIN && !hist[0].v && !hist[1].v && !hist[2].v) m_mode = M_HALT;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    step(0, nop(), 0);
    step(0, nop(), 0);
  endtask

  initial begin
    ins_t in;
    bit   rst_n, br;
    int unsigned halt_cycles;
    reset = 0; id_valid = 0; id_rs_a = '0; id_rs_b = '0; id_rs_c = '0;
    id_use_a = 0; id_use_b = 0; id_use_c = 0; id_rd = '0; id_we = 0;
    id_load = 0; id_halt = 0; ex_branch_taken = 0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;

    // Reset state
    do_reset();
    check_eq("rst_count", obs_cnt, 0);
    check_eq("rst_halted", obs_halted, 0);

    // ALU to ALU back-to-back on src A
    do_reset();
    step(1, mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    step(1, mk(1, 2, 1, 0, 1, 1, 0, 0, 0, 0, 0), 0);
    check_eq("b2b_nostall", obs_stall, 0);
    step(1, nop(), 0);
    check_eq("b2b_fwd_a", obs_fwd[0], 1);

    // Distance-2 producer on src B
    do_reset();
    step(1, mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    step(1, mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    step(1, mk(1, 7, 1, 0, 0, 0, 3, 1, 0, 0, 0), 0);
    step(1, nop(), 0);
    check_eq("dist2_fwd_b", obs_fwd[1], 2);

    // Load-use on src C: one stall cycle, then WB forwarding
    do_reset();
    step(1, mk(1, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0), 0);
    step(1, mk(1, 7, 1, 0, 0, 0, 0, 0, 4, 1, 0), 0);
    check_eq("lu_stall_on", obs_stall, 1);
    check_eq("lu_cnt_before", obs_cnt, 0);
    step(1, mk(1, 7, 1, 0, 0, 0, 0, 0, 4, 1, 0), 0);
    check_eq("lu_stall_off", obs_stall, 0);
    check_eq("lu_cnt_after", obs_cnt, 1);
    step(1, nop(), 0);
    check_eq("lu_fwd_c", obs_fwd[2], 2);

    // Same register written at distance 1 and 2: nearest wins
    do_reset();
    step(1, mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    step(1, mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    step(1, mk(1, 1, 1, 0, 5, 1, 0, 0, 0, 0, 0), 0);
    step(1, nop(), 0);
    check_eq("dbl_fwd_a", obs_fwd[0], 1);

    // Taken branch during a load-use hazard
    do_reset();
    step(1, mk(1, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0), 0);
    step(1, mk(1, 2, 1, 0, 4, 1, 0, 0, 0, 0, 0), 1);
    check_eq("br_flush", obs_flush, 1);
    check_eq("br_nostall", obs_stall, 0);
    check_eq("br_bubble", obs_bubble, 1);
    step(1, nop(), 0);
    check_eq("br_cnt", obs_cnt, 0);

    // HLT with a full pipeline, then reset out of HALTED
    do_reset();
    step(1, mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    step(1, mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    step(1, mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0);
    step(1, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 0);
    check_eq("hlt_accept", obs_stall, 0);
    step(1, nop(), 0);
    check_eq("hlt_c1", obs_halted, 0);
    check_eq("hlt_c1_stall", obs_stall, 1);
    step(1, nop(), 0);
    step(1, nop(), 0);
    check_eq("hlt_c3", obs_halted, 0);
    step(1, nop(), 0);
    check_eq("hlt_c4", obs_halted, 1);
    step(0, nop(), 0);
    step(1, mk(1, 1, 1, 0, 2, 1, 0, 0, 0, 0, 0), 0);
    check_eq("hlt_rst_halted", obs_halted, 0);
    check_eq("hlt_rst_stall", obs_stall, 0);

    // Randomized traffic
    halt_cycles = 0;
    for (int n = 0; n < 3000; n++) begin
      in.v   = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < 3; i++) begin
        in.rs[i] = NREG_W'($urandom_range(0, 3));
        in.u[i]  = $urandom_range(0, 1) != 0;
      end
      in.rd  = NREG_W'($urandom_range(0, 3));
      in.we  = ($urandom_range(0, 3) != 0);
      in.ld  = in.we && ($urandom_range(0, 3) == 0);
      in.hlt = in.v && ($urandom_range(0, 59) == 0);
      if (in.hlt) begin
        in.we = 0;
        in.ld = 0;
      end
      br = ($urandom_range(0, 9) == 0) && m_mode == M_RUN;
      halt_cycles = (m_mode == M_HALT) ? halt_cycles + 1 : 0;
      rst_n = ($urandom_range(0, 299) != 0) && (halt_cycles < 4);
      step(rst_n, in, br);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
